// File: rtl/rs5_plic_pkg.sv
// Shared constants and types for the RS5 platform-level interrupt controller.
package rs5_plic_pkg;

    localparam int PRIO_W = 3;
    localparam int ID_W   = 5;

    localparam logic [23:0] PRIO_BASE = 24'h000000;
    localparam logic [23:0] PEND_OFF  = 24'h001000;
    localparam logic [23:0] EN_OFF    = 24'h002000;
    localparam logic [23:0] THR_OFF   = 24'h200000;
    localparam logic [23:0] CLAIM_OFF = 24'h200004;

    typedef logic [PRIO_W-1:0] prio_t;

endpackage

// File: rtl/rs5_plic_gateway.sv
// Per-source gateway: pending and in-flight flags with their set/clear rules.
module rs5_plic_gateway (
    input  logic clk,
    input  logic reset_n,
    input  logic irq,
    input  logic claim,
    input  logic complete,
    output logic pending,
    output logic inflight
);

    // A claim on this edge blocks a same-cycle request; the in-flight flag
    // it sets keeps the source quiet until completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= 1'b0;
            inflight <= 1'b0;
        end else begin
            if (claim) begin
                pending  <= 1'b0;
                inflight <= 1'b1;
            end else begin
                if (irq && !inflight && !pending)
                    pending <= 1'b1;
                if (complete)
                    inflight <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rs5_plic.sv
// RS5 PLIC top: register file, max-priority arbiter, bus read mux.
// Optional acknowledge path enabled by defining RS5_PLIC_IACK_EN.
module rs5_plic
    import rs5_plic_pkg::*;
#(
    parameter int i_cnt = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic [3:0]       we_i,
    input  logic [23:0]      addr_i,
    input  logic [31:0]      data_i,
    output logic [31:0]      data_o,
    input  logic [i_cnt:1]   irq_i,
    input  logic             iack_i,
    output logic [i_cnt:1]   iack_o,
    output logic             irq_o
);

    prio_t            prio_q [1:i_cnt];
    logic [i_cnt:1]   en_q;
    prio_t            thr_q;
    logic [i_cnt:1]   pend;
    logic [i_cnt:1]   infl;
    logic [i_cnt:1]   elig;
    logic [i_cnt:1]   win_oh;
    logic [ID_W-1:0]  win_id;
    prio_t            win_prio;
    logic             win_vld;
    logic [31:0]      rdata;

    logic        rd, wr, prio_sel, claim, cmp_hit;
    logic [21:0] word;
    logic [9:0]  idx;
    logic        unused_bits;

    assign rd       = en_i && (we_i == 4'b0000);
    assign wr       = en_i && (we_i != 4'b0000);
    assign word     = addr_i[23:2];
    assign idx      = addr_i[11:2];
    assign prio_sel = (addr_i[23:12] == PRIO_BASE[23:12]);
    assign claim    = rd && (word == CLAIM_OFF[23:2]) && win_vld;
    assign cmp_hit  = wr && (word == CLAIM_OFF[23:2]);
    assign unused_bits = ^{addr_i[1:0], data_i, we_i};

    for (genvar g = 1; g <= i_cnt; g++) begin : g_gw
        rs5_plic_gateway u_gw (
            .clk      (clk),
            .reset_n  (reset_n),
            .irq      (irq_i[g]),
            .claim    (claim && (win_id == ID_W'(g))),
            .complete (cmp_hit && (data_i[ID_W-1:0] == ID_W'(g))),
            .pending  (pend[g]),
            .inflight (infl[g])
        );
    end

    // Strict '>' keeps the lowest ID on a priority tie.
    always_comb begin
        win_id   = '0;
        win_prio = '0;
        win_vld  = 1'b0;
        win_oh   = '0;
        for (int k = 1; k <= i_cnt; k++) begin
            elig[k] = pend[k] && en_q[k] && (prio_q[k] > thr_q);
            if (elig[k] && (prio_q[k] > win_prio)) begin
                win_prio = prio_q[k];
                win_id   = ID_W'(k);
                win_vld  = 1'b1;
            end
        end
        for (int k = 1; k <= i_cnt; k++)
            win_oh[k] = win_vld && (win_id == ID_W'(k));
    end

    assign irq_o = |elig;

    always_comb begin
        rdata = '0;
        if (prio_sel) begin
            for (int k = 1; k <= i_cnt; k++)
                if (idx == 10'(k))
                    rdata[PRIO_W-1:0] = prio_q[k];
        end else if (word == PEND_OFF[23:2]) begin
            rdata[i_cnt:0] = {pend, 1'b0};
        end else if (word == EN_OFF[23:2]) begin
            rdata[i_cnt:0] = {en_q, 1'b0};
        end else if (word == THR_OFF[23:2]) begin
            rdata[PRIO_W-1:0] = thr_q;
        end else if (word == CLAIM_OFF[23:2]) begin
            rdata[ID_W-1:0] = win_id;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k <= i_cnt; k++)
                prio_q[k] <= '0;
            en_q   <= '0;
            thr_q  <= '0;
            data_o <= '0;
        end else begin
            if (rd)
                data_o <= rdata;
            if (wr) begin
                if (prio_sel && we_i[0]) begin
                    for (int k = 1; k <= i_cnt; k++)
                        if (idx == 10'(k))
                            prio_q[k] <= data_i[PRIO_W-1:0];
                end
                if (word == EN_OFF[23:2]) begin
                    for (int k = 1; k <= i_cnt; k++)
                        if (we_i[k/8])
                            en_q[k] <= data_i[k];
                end
                if ((word == THR_OFF[23:2]) && we_i[0])
                    thr_q <= data_i[PRIO_W-1:0];
            end
        end
    end

`ifdef RS5_PLIC_IACK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            iack_o <= '0;
        else
            iack_o <= iack_i ? win_oh : '0;
    end
`else
    logic unused_iack;
    assign unused_iack = ^{iack_i, win_oh};
    assign iack_o      = '0;
`endif

endmodule

// File: tb/tb_rs5_plic.sv
// Directed self-checking bench for rs5_plic with four sources.
module tb_rs5_plic;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en_i = 1'b0;
    logic [3:0]    we_i = '0;
    logic [23:0]   addr_i = '0;
    logic [31:0]   data_i = '0;
    logic [31:0]   data_o;
    logic [N:1]    irq_i = '0;
    logic          iack_i = 1'b0;
    logic [N:1]    iack_o;
    logic          irq_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] rv;
    logic [N:1]  iack_exp;

    rs5_plic #(.i_cnt(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (en_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .irq_i   (irq_i),
        .iack_i  (iack_i),
        .iack_o  (iack_o),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [23:0] a, input logic [3:0] we, input logic [31:0] d);
        @(negedge clk);
        en_i = 1'b1; we_i = we; addr_i = a; data_i = d;
        @(posedge clk);
        #1;
        en_i = 1'b0; we_i = '0;
    endtask

    task automatic bus_rd(input logic [23:0] a, output logic [31:0] d);
        @(negedge clk);
        en_i = 1'b1; we_i = '0; addr_i = a;
        @(posedge clk);
        #1;
        d = data_o;
        en_i = 1'b0;
    endtask

    initial begin
`ifdef RS5_PLIC_IACK_EN
        iack_exp = 4'b0100;
`else
        iack_exp = 4'b0000;
`endif
        // Reset state
        #12;
        check("rst_data_o", data_o, 32'h0);
        check("rst_irq_o", {31'h0, irq_o}, 32'h0);
        check("rst_iack_o", {28'h0, iack_o}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic path on source 1
        bus_wr(24'h000004, 4'b0001, 32'h3);
        bus_wr(24'h002000, 4'b1111, 32'h2);
        check("basic_irq_idle", {31'h0, irq_o}, 32'h0);
        @(negedge clk);
        irq_i = 4'b0001;
        tick();
        check("basic_irq_set", {31'h0, irq_o}, 32'h1);
        bus_rd(24'h200004, rv);
        check("basic_claim", rv, 32'h1);
        check("basic_irq_after_claim", {31'h0, irq_o}, 32'h0);
        bus_wr(24'h200004, 4'b1111, 32'h1);
        check("basic_irq_cmp_edge", {31'h0, irq_o}, 32'h0);
        tick();
        check("basic_repend", {31'h1f, irq_o}, 32'h3f);
        bus_rd(24'h200004, rv);
        check("basic_claim2", rv, 32'h1);
        @(negedge clk);
        irq_i = '0;
        bus_wr(24'h200004, 4'b1111, 32'h1);
        tick();
        check("basic_no_repend", {31'h0, irq_o}, 32'h0);

        // Threshold
        bus_wr(24'h000004, 4'b0001, 32'h2);
        bus_wr(24'h200000, 4'b0001, 32'h2);
        @(negedge clk);
        irq_i = 4'b0001;
        tick();
        check("thr_blocked", {31'h0, irq_o}, 32'h0);
        bus_rd(24'h001000, rv);
        check("thr_pending", rv, 32'h2);
        bus_wr(24'h200000, 4'b0001, 32'h1);
        check("thr_pass", {31'h0, irq_o}, 32'h1);
        bus_rd(24'h200000, rv);
        check("thr_readback", rv, 32'h1);
        bus_rd(24'h200004, rv);
        check("thr_claim", rv, 32'h1);
        @(negedge clk);
        irq_i = '0;
        bus_wr(24'h200004, 4'b1111, 32'h1);
        bus_wr(24'h200000, 4'b0001, 32'h0);

        // Arbitration: priorities {1:2, 2:5, 3:5, 4:1}
        bus_wr(24'h000004, 4'b0001, 32'h2);
        bus_wr(24'h000008, 4'b0001, 32'h5);
        bus_wr(24'h00000C, 4'b0001, 32'h5);
        bus_wr(24'h000010, 4'b0001, 32'h1);
        bus_wr(24'h002000, 4'b1111, 32'h1E);
        @(negedge clk);
        irq_i = 4'b1111;
        tick();
        @(negedge clk);
        irq_i = '0;
        bus_rd(24'h001000, rv);
        check("arb_pending", rv, 32'h1E);
        bus_rd(24'h200004, rv);
        check("arb_claim_a", rv, 32'h2);

        // Acknowledge with winner 3
        @(negedge clk);
        iack_i = 1'b1;
        tick();
        check("iack_pulse", {28'h0, iack_o}, {28'h0, iack_exp});
        iack_i = 1'b0;
        tick();
        check("iack_one_cycle", {28'h0, iack_o}, 32'h0);

        bus_rd(24'h200004, rv);
        check("arb_claim_b", rv, 32'h3);
        bus_rd(24'h200004, rv);
        check("arb_claim_c", rv, 32'h1);
        bus_rd(24'h200004, rv);
        check("arb_claim_d", rv, 32'h4);
        bus_rd(24'h200004, rv);
        check("arb_claim_none", rv, 32'h0);
        check("arb_irq_idle", {31'h0, irq_o}, 32'h0);

        // Bus edges: all four in flight while requests stay high
        @(negedge clk);
        irq_i = 4'b1111;
        tick();
        bus_wr(24'h001000, 4'b1111, 32'hFFFF_FFFF);
        bus_rd(24'h001000, rv);
        check("edge_pend_wr_ignored", rv, 32'h0);
        bus_wr(24'h200004, 4'b1111, 32'h7);
        tick();
        bus_rd(24'h001000, rv);
        check("edge_cmp7_ignored", rv, 32'h0);
        bus_wr(24'h200004, 4'b1111, 32'h2);
        tick();
        bus_rd(24'h001000, rv);
        check("edge_cmp2_repend", rv, 32'h4);
        check("edge_irq_src2", {31'h0, irq_o}, 32'h1);
        bus_rd(24'h002000, rv);
        check("edge_en_read", rv, 32'h1E);
        bus_rd(24'h003000, rv);
        check("edge_unmapped", rv, 32'h0);
        bus_wr(24'h002000, 4'b0010, 32'h0);
        bus_rd(24'h002000, rv);
        check("edge_lane1_only", rv, 32'h1E);
        bus_wr(24'h002000, 4'b0001, 32'hFFFF_FFFF);
        bus_rd(24'h002000, rv);
        check("edge_en_mask", rv, 32'h1E);
        bus_rd(24'h000000, rv);
        check("edge_prio0", rv, 32'h0);
        bus_rd(24'h000008, rv);
        check("edge_prio2", rv, 32'h5);

        // Reset mid-operation
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst_data_o", data_o, 32'h0);
        check("mid_rst_irq_o", {31'h0, irq_o}, 32'h0);
        check("mid_rst_iack_o", {28'h0, iack_o}, 32'h0);
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        bus_rd(24'h002000, rv);
        check("post_rst_en", rv, 32'h0);
        bus_rd(24'h200004, rv);
        check("post_rst_claim", rv, 32'h0);
        bus_rd(24'h001000, rv);
        check("post_rst_repend", rv, 32'h1E);
        check("post_rst_irq", {31'h0, irq_o}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
